// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Covers state codes, opcodes, ALU operation codes and datapath select encodings.
// Also provides the immediate-format decode used by the top.
package riscv_mc_pkg;

    localparam int STATE_W_DEF = 4;
    localparam int ALUC_W_DEF  = 3;

    // State codes; TRAP is only reachable when ILLEGAL_TRAP_EN is defined
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWRITE = 4'd4;
    localparam logic [3:0] ST_MEMWB    = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_JAL      = 4'd9;
    localparam logic [3:0] ST_BEQ      = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    // Opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ALUOp from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format from opcode; unknown opcodes fall back to I-format
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multicycle control FSM and the datapath.
// master = control unit (drives enables/selects), slave = datapath.
interface multicycle_control_fsm_if;
    import riscv_mc_pkg::*;

    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  Zero;
    logic                  PCWrite;
    logic                  AdrSrc;
    logic                  MemWrite;
    logic                  IRWrite;
    logic [1:0]            ResultSrc;
    logic [1:0]            ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic                  RegWrite;
    logic [1:0]            ImmSrc;
    logic [ALUC_W_DEF-1:0] ALUControl;
    logic                  illegal_instr;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, illegal_instr
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, ALUControl, illegal_instr
    );

endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction function fields to ALUControl.
// op[5] separates R-type (sub allowed) from I-type (addi ignores instr[30]).
module alu_decoder
    import riscv_mc_pkg::*;
#(
    parameter int ALUC_W = ALUC_W_DEF
) (
    input  aluop_e            i_aluop,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7b5,
    input  logic              i_op5,
    output logic [ALUC_W-1:0] o_alucontrol
);

    // Select the ALU operation from ALUOp, decoding funct fields when asked to
    always_comb begin
        o_alucontrol = ALUC_W'(ALU_ADD);
        case (i_aluop)
            ALUOP_SUB: o_alucontrol = ALUC_W'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alucontrol = (i_op5 && i_funct7b5) ? ALUC_W'(ALU_SUB)
                                                                  : ALUC_W'(ALU_ADD);
                    3'b010:  o_alucontrol = ALUC_W'(ALU_SLT);
                    3'b110:  o_alucontrol = ALUC_W'(ALU_OR);
                    3'b111:  o_alucontrol = ALUC_W'(ALU_AND);
                    default: o_alucontrol = ALUC_W'(ALU_ADD);
                endcase
            end
            default: o_alucontrol = ALUC_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit for the multicycle RV32I core (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects,
// write enables and ALUControl. While rst_n is low every output is forced to 0.
// Optional feature: define ILLEGAL_TRAP_EN to lock unsupported opcodes in a
// TRAP state with a sticky illegal_instr flag; otherwise they execute as NOPs.
module multicycle_control_fsm
    import riscv_mc_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int ALUC_W  = ALUC_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_fsm_if.master  bus
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(ST_FETCH),
        DECODE   = STATE_W'(ST_DECODE),
        MEMADR   = STATE_W'(ST_MEMADR),
        MEMREAD  = STATE_W'(ST_MEMREAD),
        MEMWRITE = STATE_W'(ST_MEMWRITE),
        MEMWB    = STATE_W'(ST_MEMWB),
        EXECUTER = STATE_W'(ST_EXECUTER),
        EXECUTEI = STATE_W'(ST_EXECUTEI),
        ALUWB    = STATE_W'(ST_ALUWB),
        JAL      = STATE_W'(ST_JAL),
        BEQ      = STATE_W'(ST_BEQ)
`ifdef ILLEGAL_TRAP_EN
        ,TRAP    = STATE_W'(ST_TRAP)
`endif
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              w_pcupdate;
    logic              w_branch;
    logic              w_adrsrc;
    logic              w_memwrite;
    logic              w_irwrite;
    logic              w_regwrite;
    logic [1:0]        w_resultsrc;
    logic [1:0]        w_alusrca;
    logic [1:0]        w_alusrcb;
    aluop_e            w_aluop;
    logic [ALUC_W-1:0] w_alucontrol;

    // State register; reset (synchronous) returns to FETCH and aborts any instruction
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= FETCH;
        else        r_state <= w_state_nxt;
    end

    // Next-state and Moore output decode
    always_comb begin
        w_state_nxt = r_state;
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = RES_ALUOUT;
        w_alusrca   = SRCA_PC;
        w_alusrcb   = SRCB_RS2;
        w_aluop     = ALUOP_ADD;
        case (r_state)
            FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = SRCB_FOUR;
                w_resultsrc = RES_ALURES;
                w_pcupdate  = 1'b1;
                w_state_nxt = DECODE;
            end
            DECODE: begin
                // ALUOut captures OldPC + imm so BEQ can load the target
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: w_state_nxt = MEMADR;
                    OP_R:         w_state_nxt = EXECUTER;
                    OP_I:         w_state_nxt = EXECUTEI;
                    OP_JAL:       w_state_nxt = JAL;
                    OP_BEQ:       w_state_nxt = BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      w_state_nxt = TRAP;
`else
                    default:      w_state_nxt = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                w_alusrca   = SRCA_RS1;
                w_alusrcb   = SRCB_IMM;
                w_state_nxt = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                w_adrsrc    = 1'b1;
                w_state_nxt = MEMWB;
            end
            MEMWRITE: begin
                w_adrsrc    = 1'b1;
                w_memwrite  = 1'b1;
                w_state_nxt = FETCH;
            end
            MEMWB: begin
                w_resultsrc = RES_DATA;
                w_regwrite  = 1'b1;
                w_state_nxt = FETCH;
            end
            EXECUTER: begin
                w_alusrca   = SRCA_RS1;
                w_alusrcb   = SRCB_RS2;
                w_aluop     = ALUOP_FUNCT;
                w_state_nxt = ALUWB;
            end
            EXECUTEI: begin
                w_alusrca   = SRCA_RS1;
                w_alusrcb   = SRCB_IMM;
                w_aluop     = ALUOP_FUNCT;
                w_state_nxt = ALUWB;
            end
            ALUWB: begin
                w_regwrite  = 1'b1;
                w_state_nxt = FETCH;
            end
            JAL: begin
                // OldPC + 4 is the link value; PC takes the target held in ALUOut
                w_alusrca   = SRCA_OLDPC;
                w_alusrcb   = SRCB_FOUR;
                w_pcupdate  = 1'b1;
                w_state_nxt = ALUWB;
            end
            BEQ: begin
                w_alusrca   = SRCA_RS1;
                w_alusrcb   = SRCB_RS2;
                w_aluop     = ALUOP_SUB;
                w_branch    = 1'b1;
                w_state_nxt = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: w_state_nxt = TRAP;
`endif
            default: w_state_nxt = FETCH;
        endcase
    end

    alu_decoder #(
        .ALUC_W (ALUC_W)
    ) u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct3     (bus.funct3),
        .i_funct7b5   (bus.funct7b5),
        .i_op5        (bus.op[5]),
        .o_alucontrol (w_alucontrol)
    );

    // Reset gating: nothing writes and every select is 0 while rst_n is low.
    // PCWrite follows Zero combinationally in BEQ.
    assign bus.PCWrite    = rst_n & (w_pcupdate | (w_branch & bus.Zero));
    assign bus.AdrSrc     = rst_n & w_adrsrc;
    assign bus.MemWrite   = rst_n & w_memwrite;
    assign bus.IRWrite    = rst_n & w_irwrite;
    assign bus.RegWrite   = rst_n & w_regwrite;
    assign bus.ResultSrc  = rst_n ? w_resultsrc : RES_ALUOUT;
    assign bus.ALUSrcA    = rst_n ? w_alusrca : SRCA_PC;
    assign bus.ALUSrcB    = rst_n ? w_alusrcb : SRCB_RS2;
    assign bus.ImmSrc     = rst_n ? imm_src(bus.op) : IMM_I;
    assign bus.ALUControl = rst_n ? w_alucontrol : ALUC_W'(ALU_ADD);

`ifdef ILLEGAL_TRAP_EN
    // The flag is the TRAP state itself: set the cycle after DECODE, held until reset
    assign bus.illegal_instr = rst_n & (r_state == TRAP);
`else
    assign bus.illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// state by state and compares every output against hand-computed vectors.
module tb_multicycle_control_fsm;
    import riscv_mc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    multicycle_control_fsm_if ctrl ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {illegal, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALUControl}
    logic [14:0] w_out;
    assign w_out = {ctrl.illegal_instr, ctrl.PCWrite, ctrl.AdrSrc, ctrl.MemWrite, ctrl.IRWrite,
                    ctrl.ResultSrc, ctrl.ALUSrcA, ctrl.ALUSrcB, ctrl.RegWrite, ctrl.ALUControl};

    //                                ill   pcw   adr   mw    ir    rs     a      b      rw    alu
    localparam logic [14:0] V_ZERO = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [14:0] V_F    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000};
    localparam logic [14:0] V_D    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 3'b000};
    localparam logic [14:0] V_MA   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000};
    localparam logic [14:0] V_MR   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [14:0] V_MW   = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};
    localparam logic [14:0] V_MWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 3'b000};
    localparam logic [14:0] V_AWB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000};
    localparam logic [14:0] V_J    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 3'b000};
    localparam logic [14:0] V_TRAP = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000};

    function automatic logic [14:0] v_er(input logic [2:0] alu);
        v_er = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, alu};
    endfunction

    function automatic logic [14:0] v_ei(input logic [2:0] alu);
        v_ei = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, alu};
    endfunction

    function automatic logic [14:0] v_beq(input logic z);
        v_beq = {1'b0, z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001};
    endfunction

    task automatic check(input string tag, input logic [14:0] act, input logic [14:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, act, exp);
    endtask

    // Compare outputs mid-cycle, then advance to just after the next rising edge
    task automatic cyc(input string tag, input logic [14:0] exp);
        @(negedge clk);
        check(tag, w_out, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z);
        ctrl.op       = op;
        ctrl.funct3   = f3;
        ctrl.funct7b5 = f7;
        ctrl.Zero     = z;
    endtask

    task automatic run_r(input string tag, input logic [2:0] f3, input logic f7,
                         input logic [2:0] alu);
        set_instr(OP_R, f3, f7, 1'b0);
        cyc({tag, "_F"}, V_F);
        cyc({tag, "_D"}, V_D);
        cyc({tag, "_EX"}, v_er(alu));
        cyc({tag, "_WB"}, V_AWB);
    endtask

    task automatic run_i(input string tag, input logic [2:0] f3, input logic f7,
                         input logic [2:0] alu);
        set_instr(OP_I, f3, f7, 1'b0);
        cyc({tag, "_F"}, V_F);
        cyc({tag, "_D"}, V_D);
        cyc({tag, "_EX"}, v_ei(alu));
        cyc({tag, "_WB"}, V_AWB);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        set_instr(OP_SW, 3'b000, 1'b0, 1'b1);
        #1;
        check("imm_in_reset", 15'(ctrl.ImmSrc), 15'(IMM_I));
        cyc("por0", V_ZERO);
        cyc("por1", V_ZERO);
        rst_n = 1'b1;

        // Reset held two cycles from MEMREAD of a lw, then released
        set_instr(OP_LW, 3'b010, 1'b0, 1'b0);
        cyc("t1_F", V_F);
        cyc("t1_D", V_D);
        cyc("t1_MA", V_MA);
        rst_n = 1'b0;
        cyc("t1_rst_mr", V_ZERO);
        cyc("t1_rst_2", V_ZERO);
        rst_n = 1'b1;
        cyc("t1_F_after", V_F);
        cyc("t1_D_after", V_D);
        cyc("t1_MA_after", V_MA);
        cyc("t1_MR_after", V_MR);
        cyc("t1_WB_after", V_MWB);

        // lw: five cycles, RegWrite only in the last
        check("imm_lw", 15'(ctrl.ImmSrc), 15'(IMM_I));
        cyc("lw_F", V_F);
        cyc("lw_D", V_D);
        cyc("lw_MA", V_MA);
        cyc("lw_MR", V_MR);
        cyc("lw_WB", V_MWB);

        // R-type and I-type ALU decode
        run_r("add", 3'b000, 1'b0, 3'b000);
        run_r("sub", 3'b000, 1'b1, 3'b001);
        run_r("slt", 3'b010, 1'b0, 3'b101);
        run_r("or", 3'b110, 1'b0, 3'b011);
        run_r("and", 3'b111, 1'b0, 3'b010);
        run_r("xor", 3'b100, 1'b0, 3'b000);
        run_i("addi", 3'b000, 1'b1, 3'b000);
        run_i("slti", 3'b010, 1'b0, 3'b101);

        // beq taken and not taken
        set_instr(OP_BEQ, 3'b000, 1'b0, 1'b1);
        #1;
        check("imm_beq", 15'(ctrl.ImmSrc), 15'(IMM_B));
        cyc("beqT_F", V_F);
        cyc("beqT_D", V_D);
        cyc("beqT_BEQ", v_beq(1'b1));
        ctrl.Zero = 1'b0;
        cyc("beqN_F", V_F);
        cyc("beqN_D", V_D);
        cyc("beqN_BEQ", v_beq(1'b0));

        // sw: MemWrite only in cycle 4
        set_instr(OP_SW, 3'b010, 1'b0, 1'b0);
        #1;
        check("imm_sw", 15'(ctrl.ImmSrc), 15'(IMM_S));
        cyc("sw_F", V_F);
        cyc("sw_D", V_D);
        cyc("sw_MA", V_MA);
        cyc("sw_MW", V_MW);

        // jal
        set_instr(OP_JAL, 3'b000, 1'b0, 1'b1);
        #1;
        check("imm_jal", 15'(ctrl.ImmSrc), 15'(IMM_J));
        cyc("jal_F", V_F);
        cyc("jal_D", V_D);
        cyc("jal_J", V_J);
        cyc("jal_WB", V_AWB);

        // Unsupported opcode
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        cyc("ill_F", V_F);
        cyc("ill_D", V_D);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 12; i++) cyc("ill_trap", V_TRAP);
        rst_n = 1'b0;
        cyc("ill_rst", V_ZERO);
        rst_n = 1'b1;
        set_instr(OP_LW, 3'b010, 1'b0, 1'b0);
        cyc("ill_F_after", V_F);
        cyc("ill_D_after", V_D);
`else
        cyc("ill_F2", V_F);
        cyc("ill_D2", V_D);
        set_instr(OP_JAL, 3'b000, 1'b0, 1'b0);
        cyc("ill_F3", V_F);
        cyc("ill_D3", V_D);
        cyc("ill_J3", V_J);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
